hit_detector: RTL
=================

// Module: hit_detector
// PURPOSE
//  Per-frame player/bullet collision stage feeding health.is_hit. On each frame_tick it
//  scans the bullet table (1-cycle-latency sync-read RAM), does an AABB overlap test against
//  the player hitbox, and on the first overlap raises is_hit. is_hit is held long enough for
//  the health stage's slow sampling tick to see it. It also orders the hit bullet cleared and
//  applies invincibility frames.
// PARAMETERS
//  N_BULLETS   32        bullet table entries; power of two
//  ADDR_W      5         log2(N_BULLETS)
//  COORD_W     10        unsigned x/y coordinate width, in pixels
//  PLAYER_HALF 4         player hitbox half-size, in pixels
//  BULLET_HALF 2         bullet hitbox half-size, in pixels
//  IFRAMES     60        frames of invincibility after a reported hit
//  HIT_HOLD    1000001   cycles is_hit stays high; must exceed health sampling period (1000000)
// PORTS
//  clk          in   1        system clock; sole clock domain
//  rst          in   1        synchronous, active-high reset
//  frame_tick   in   1        1-cycle pulse, start of frame
//  die          in   1        from health; while high no new hit is reported
//  player_x     in   COORD_W  player centre x; sampled on the accepted frame_tick
//  player_y     in   COORD_W  player centre y; sampled on the accepted frame_tick
//  bullet_addr  out  ADDR_W   bullet RAM read address
//  bullet_valid in   1        RAM data: entry live
//  bullet_x     in   COORD_W  RAM data: bullet centre x
//  bullet_y     in   COORD_W  RAM data: bullet centre y
//  is_hit       out  1        level to health; high for HIT_HOLD cycles per hit
//  hit_clear    out  1        1-cycle pulse: bullet owner must invalidate entry hit_idx
//  hit_idx      out  ADDR_W   index of the bullet that hit; valid with hit_clear
//  busy         out  1        scan in progress
//  invincible   out  1        i-frame counter nonzero
//  scan_overrun out  1        1-cycle pulse: frame_tick arrived while busy
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; hold and i-frame counters 0. rst mid-scan aborts, no hit.
//  FSM IDLE -> SCAN -> DRAIN -> IDLE.
//   IDLE: frame_tick && !invincible && !die -> latch player_x/y, bullet_addr=0, busy=1, SCAN.
//         frame_tick && invincible -> decrement i-frame counter only; stay IDLE.
//         frame_tick && die -> ignored.
//   SCAN: bullet_addr increments by 1 every cycle. After addr N_BULLETS-1 is issued -> DRAIN.
//   DRAIN: evaluates the last returned entry, then -> IDLE with busy=0.
//  Pipeline: addr i issued in cycle c. Data arrives in cycle c+1. Compare result is registered
//   at end of c+1. No-hit scan: busy high exactly N_BULLETS+1 cycles.
//  Overlap test (unsigned, COORD_W+1-bit differences):
//   bullet_valid && |px-bx| <= PLAYER_HALF+BULLET_HALF && |py-by| <= same.
//   Equality counts as hit. No wrap: |a-b| = (a>=b) ? a-b : b-a.
//  First hit (lowest index) wins. In the same cycle as the registered result:
//   - hit_clear=1 and hit_idx=i for one cycle.
//   - is_hit=1; hold counter = HIT_HOLD-1.
//   - i-frame counter = IFRAMES.
//   - abort scan -> IDLE, busy=0.
//  is_hit falls when the hold counter reaches 0. The counter runs independently of the FSM.
//  invincible = (i-frame counter != 0); it decrements once per frame_tick, saturating at 0.
//  frame_tick while busy: scan continues, tick otherwise ignored (no i-frame decrement),
//   scan_overrun pulses.
//  die rising mid-scan: results of that scan are discarded (no hit_clear, no is_hit).
//   Any is_hit already high completes its hold.
// STRUCTURE
//  stg_defs.vh: COORD_W, N_BULLETS, ADDR_W, FSM state localparams
//   (IDLE=2'd0, SCAN=2'd1, DRAIN=2'd2), health TIME_MAX.
//  Sub-module aabb_overlap (combinational): two points + summed half-size -> overlap bit.
//  Top level holds FSM, address counter, compare register, hold and i-frame counters.
// TESTING
//  1 rst, no ticks -> all outputs 0, bullet_addr 0.
//  2 tick, all entries invalid -> busy 33 cycles, addr 0..31, no is_hit/hit_clear.
//  3 player (100,100), entry 5 at (106,94) -> hit_clear 1 cycle with hit_idx=5;
//    is_hit high exactly 1000001 cycles; busy drops with hit_clear.
//    Same case with entry 5 at (107,100) -> no hit.
//  4 entries 3 and 9 both overlap -> hit_idx=3 only.
//    Next 60 ticks: no scan, invincible=1. 61st tick scans (busy=1).
//  5 tick during scan -> scan_overrun pulse, scan finishes normally;
//    rst at addr 10 -> busy 0 next cycle, no hit.
//  6 die=1 then tick with overlap -> no scan, no is_hit;
//    die rises mid-scan before overlapping entry -> no hit_clear.

Source files
------------

// File: rtl/hit_detector_pkg.sv
// Shared defaults and FSM encoding for the per-frame player/bullet collision stage.
package hit_detector_pkg;
  localparam int DEF_N_BULLETS   = 32;
  localparam int DEF_COORD_W     = 10;
  localparam int DEF_PLAYER_HALF = 4;
  localparam int DEF_BULLET_HALF = 2;
  localparam int DEF_IFRAMES     = 60;
  localparam int DEF_HIT_HOLD    = 1000001;
  // health samples is_hit once per TIME_MAX cycles, so DEF_HIT_HOLD must exceed it
  localparam int TIME_MAX        = 1000000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } state_e;
endpackage

// File: rtl/hit_detector_aabb_overlap.sv
// Axis-aligned box overlap of two centre points against a summed half-size.
module aabb_overlap #(
  parameter int COORD_W = 10,
  parameter int HALF    = 6
) (
  input  logic [COORD_W-1:0] ax,
  input  logic [COORD_W-1:0] ay,
  input  logic [COORD_W-1:0] bx,
  input  logic [COORD_W-1:0] by,
  output logic               overlap
);
  localparam logic [COORD_W:0] LIM = (COORD_W+1)'(HALF);

  logic [COORD_W:0] dx, dy;

  // Absolute differences without wrap: the screen edge is not adjacent to the opposite edge.
  always_comb begin
    dx      = (ax >= bx) ? ({1'b0, ax} - {1'b0, bx}) : ({1'b0, bx} - {1'b0, ax});
    dy      = (ay >= by) ? ({1'b0, ay} - {1'b0, by}) : ({1'b0, by} - {1'b0, ay});
    overlap = (dx <= LIM) && (dy <= LIM);
  end
endmodule

// File: rtl/hit_detector.sv
// Per-frame scan of the bullet table against the player hitbox; reports the first hit,
// holds is_hit for the health stage and applies invincibility frames.
module hit_detector
  import hit_detector_pkg::*;
#(
  parameter int N_BULLETS   = DEF_N_BULLETS,
  parameter int ADDR_W      = $clog2(N_BULLETS),
  parameter int COORD_W     = DEF_COORD_W,
  parameter int PLAYER_HALF = DEF_PLAYER_HALF,
  parameter int BULLET_HALF = DEF_BULLET_HALF,
  parameter int IFRAMES     = DEF_IFRAMES,
  parameter int HIT_HOLD    = DEF_HIT_HOLD
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               die,
  input  logic [COORD_W-1:0] player_x,
  input  logic [COORD_W-1:0] player_y,
  output logic [ADDR_W-1:0]  bullet_addr,
  input  logic               bullet_valid,
  input  logic [COORD_W-1:0] bullet_x,
  input  logic [COORD_W-1:0] bullet_y,
  output logic               is_hit,
  output logic               hit_clear,
  output logic [ADDR_W-1:0]  hit_idx,
  output logic               busy,
  output logic               invincible,
  output logic               scan_overrun
);
  localparam int HOLD_W = $clog2(HIT_HOLD + 1);
  localparam int IFR_W  = $clog2(IFRAMES + 1);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_BULLETS - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d, rd_idx_q, rd_idx_d, hit_idx_q, hit_idx_d;
  logic                rd_vld_q, rd_vld_d, discard_q, discard_d;
  logic                busy_q, busy_d, hit_clear_q, hit_clear_d;
  logic                is_hit_q, is_hit_d, overrun_q, overrun_d;
  logic [COORD_W-1:0]  px_q, px_d, py_q, py_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [IFR_W-1:0]    ifr_q, ifr_d;
  logic                overlap, hit;

  aabb_overlap #(
    .COORD_W (COORD_W),
    .HALF    (PLAYER_HALF + BULLET_HALF)
  ) u_aabb (
    .ax      (px_q),
    .ay      (py_q),
    .bx      (bullet_x),
    .by      (bullet_y),
    .overlap (overlap)
  );

  // rd_vld_q marks a cycle whose RAM data belongs to an address issued by this scan.
  assign hit = rd_vld_q && bullet_valid && overlap && !die && !discard_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = '0;
    rd_vld_d    = 1'b0;
    rd_idx_d    = addr_q;
    discard_d   = discard_q;
    px_d        = px_q;
    py_d        = py_q;
    hit_clear_d = 1'b0;
    hit_idx_d   = hit_idx_q;
    overrun_d   = 1'b0;
    ifr_d       = ifr_q;
    hold_d      = hold_q;
    is_hit_d    = is_hit_q;

    if (hold_q != '0) hold_d = hold_q - 1'b1;
    else              is_hit_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (frame_tick) begin
          if (ifr_q != '0) begin
            ifr_d = ifr_q - 1'b1;
          end else if (!die) begin
            state_d   = SCAN;
            px_d      = player_x;
            py_d      = player_y;
            discard_d = 1'b0;
          end
        end
      end
      SCAN: begin
        addr_d   = addr_q + 1'b1;
        rd_vld_d = 1'b1;
        if (addr_q == LAST) state_d = DRAIN;
      end
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE) begin
      overrun_d = frame_tick;
      if (die) discard_d = 1'b1;
    end

    if (hit) begin
      state_d     = IDLE;
      addr_d      = '0;
      rd_vld_d    = 1'b0;
      hit_clear_d = 1'b1;
      hit_idx_d   = rd_idx_q;
      is_hit_d    = 1'b1;
      hold_d      = HOLD_W'(HIT_HOLD - 1);
      ifr_d       = IFR_W'(IFRAMES);
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rd_idx_q    <= '0;
      rd_vld_q    <= 1'b0;
      discard_q   <= 1'b0;
      px_q        <= '0;
      py_q        <= '0;
      busy_q      <= 1'b0;
      hit_clear_q <= 1'b0;
      hit_idx_q   <= '0;
      is_hit_q    <= 1'b0;
      overrun_q   <= 1'b0;
      hold_q      <= '0;
      ifr_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rd_idx_q    <= rd_idx_d;
      rd_vld_q    <= rd_vld_d;
      discard_q   <= discard_d;
      px_q        <= px_d;
      py_q        <= py_d;
      busy_q      <= busy_d;
      hit_clear_q <= hit_clear_d;
      hit_idx_q   <= hit_idx_d;
      is_hit_q    <= is_hit_d;
      overrun_q   <= overrun_d;
      hold_q      <= hold_d;
      ifr_q       <= ifr_d;
    end
  end

  assign bullet_addr  = addr_q;
  assign busy         = busy_q;
  assign hit_clear    = hit_clear_q;
  assign hit_idx      = hit_idx_q;
  assign is_hit       = is_hit_q;
  assign scan_overrun = overrun_q;
  assign invincible   = (ifr_q != '0);
endmodule
